serial_compare: RTL

SERIAL_COMPARE -- requirements
Module: serial_compare

---
 rtl/serial_compare_pkg.sv | 19 +
 rtl/serial_compare_chunk_compare.sv | 16 +
 rtl/serial_compare.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serial_compare_pkg.sv
// Shared definitions for serial_compare: FSM state encoding and default operand/chunk widths.
// Optional early-exit scanning is selected by COMPARE_EARLY_EXIT_EN (see serial_compare.sv).
package serial_compare_pkg;

    localparam int DEFAULT_NUM_SIZE   = 32;
    localparam int DEFAULT_CHUNK_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a chunk index; at least one bit so a single-chunk build still has a counter.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/serial_compare_chunk_compare.sv
// Combinational compare of one CHUNK_SIZE-wide slice of the two operands.
module chunk_compare
    import serial_compare_pkg::*;
#(
    parameter int CHUNK_SIZE = DEFAULT_CHUNK_SIZE
) (
    input  logic [CHUNK_SIZE-1:0] i_left,
    input  logic [CHUNK_SIZE-1:0] i_right,
    output logic                  o_eq,
    output logic                  o_gt
);

    assign o_eq = (i_left == i_right);
    assign o_gt = (i_left > i_right);

endmodule

// File: rtl/serial_compare.sv
// Multi-cycle magnitude comparator scanning operands one chunk per cycle, MSB chunk first.
// Define COMPARE_EARLY_EXIT_EN to leave SCAN as soon as the first differing chunk is seen.
module serial_compare
    import serial_compare_pkg::*;
#(
    parameter int NUM_SIZE   = DEFAULT_NUM_SIZE,
    parameter int CHUNK_SIZE = DEFAULT_CHUNK_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_SIZE-1:0] leftOperand,
    input  logic [NUM_SIZE-1:0] rightOperand,
    input  logic                isSigned,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                equal,
    output logic                greaterThan,
    output logic                lessThan,
    output logic [1:0]          dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and the result is held until its transfer completes.

    localparam int NCHUNK = NUM_SIZE / CHUNK_SIZE;
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [NUM_SIZE-1:0]   r_left;
    logic [NUM_SIZE-1:0]   r_right;
    logic                  r_signed;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_found;
    logic                  r_gt;

    logic [NUM_SIZE-1:0]   w_left_adj;
    logic [NUM_SIZE-1:0]   w_right_adj;
    logic [CHUNK_SIZE-1:0] w_left_chunk;
    logic [CHUNK_SIZE-1:0] w_right_chunk;
    logic                  w_ch_eq;
    logic                  w_ch_gt;
    logic                  w_first_diff;
    logic                  w_accept;
    logic                  w_last_chunk;

    // Flipping the sign bit maps two's-complement ordering onto unsigned ordering.
    always_comb begin
        w_left_adj                = r_left;
        w_right_adj               = r_right;
        w_left_adj[NUM_SIZE-1]    = r_left[NUM_SIZE-1] ^ r_signed;
        w_right_adj[NUM_SIZE-1]   = r_right[NUM_SIZE-1] ^ r_signed;
    end

    always_comb begin
        w_left_chunk  = '0;
        w_right_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_left_chunk  = w_left_adj[i*CHUNK_SIZE +: CHUNK_SIZE];
                w_right_chunk = w_right_adj[i*CHUNK_SIZE +: CHUNK_SIZE];
            end
        end
    end

    chunk_compare #(
        .CHUNK_SIZE (CHUNK_SIZE)
    ) u_chunk_compare (
        .i_left  (w_left_chunk),
        .i_right (w_right_chunk),
        .o_eq    (w_ch_eq),
        .o_gt    (w_ch_gt)
    );

    assign w_accept     = (r_state == IDLE) && in_valid;
    assign w_first_diff = (r_state == SCAN) && !r_found && !w_ch_eq;
    assign w_last_chunk = (r_idx == '0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next_state = SCAN;
                end
            end
            SCAN: begin
`ifdef COMPARE_EARLY_EXIT_EN
                if (w_last_chunk || w_first_diff) begin
                    w_next_state = DONE;
                end
`else
                if (w_last_chunk) begin
                    w_next_state = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left   <= '0;
            r_right  <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_found  <= 1'b0;
            r_gt     <= 1'b0;
        end else if (w_accept) begin
            r_left   <= leftOperand;
            r_right  <= rightOperand;
            r_signed <= isSigned;
            r_idx    <= LAST_IDX;
            r_found  <= 1'b0;
            r_gt     <= 1'b0;
        end else if (r_state == SCAN) begin
            // Only the first differing chunk decides; lower chunks are ignored afterwards.
            if (w_first_diff) begin
                r_found <= 1'b1;
                r_gt    <= w_ch_gt;
            end
            if (!w_last_chunk) begin
                r_idx <= r_idx - IDX_W'(1);
            end
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign equal       = out_valid && !r_found;
    assign greaterThan = out_valid && r_found && r_gt;
    assign lessThan    = out_valid && r_found && !r_gt;
    assign dbg_state   = r_state;

endmodule
